// File: rtl/pll_rst_pkg.sv
// Shared types and defaults for the PLL-driven reset sequencer and clock-enable generator.
package pll_rst_pkg;

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      HOLD      = 2'd1,
      RUN       = 2'd2
   } pll_state_t;

   localparam int DEFAULT_HOLD_CYCLES = 1024;
   localparam int DEFAULT_CE_DIV      = 6;

   function automatic logic [7:0] sat_inc8(input logic [7:0] value);
      return (value == 8'hFF) ? value : value + 8'd1;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level into the clk domain.
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pll_rst_ce_gen.sv
// Holds the core in reset until the PLL has been stably locked, then produces
// the pixel and CPU clock enables; counts lock losses seen while running.
module pll_rst_ce_gen
   import pll_rst_pkg::*;
#(
   parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES,
   parameter int CE_DIV      = DEFAULT_CE_DIV
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pll_locked,
   input  logic       ext_reset,
   output logic       sys_reset,
   output logic       ready,
   output logic       ce_pix,
   output logic       ce_cpu,
   output logic [7:0] lock_lost_cnt
);

   localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);
   localparam logic [7:0]  DIV_LAST  = 8'(CE_DIV - 1);

   pll_state_t  state, state_next;
   logic        locked_s;
   logic [15:0] hold_cnt, hold_next;
   logic [7:0]  lost_next;
   logic [7:0]  div_cnt;
   logic        phase;
   logic        run_stay;

   sync_2ff u_lock_sync (
      .clk (clk),
      .rst (rst),
      .d   (pll_locked),
      .q   (locked_s)
   );

   // sys_reset/ready are registered from the next state so they track the state exactly
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= WAIT_LOCK;
         hold_cnt      <= '0;
         lock_lost_cnt <= '0;
         sys_reset     <= 1'b1;
         ready         <= 1'b0;
      end else begin
         state         <= state_next;
         hold_cnt      <= hold_next;
         lock_lost_cnt <= lost_next;
         sys_reset     <= (state_next != RUN);
         ready         <= (state_next == RUN);
      end
   end

   always_comb begin
      state_next = state;
      hold_next  = hold_cnt;
      lost_next  = lock_lost_cnt;
      case (state)
         WAIT_LOCK: begin
            if (locked_s) begin
               state_next = HOLD;
               hold_next  = '0;
            end
         end
         HOLD: begin
            if (!locked_s) begin
               state_next = WAIT_LOCK;
               hold_next  = '0;
            end else if (ext_reset) begin
               hold_next = '0;
            end else if (hold_cnt == HOLD_LAST) begin
               state_next = RUN;
               hold_next  = '0;
            end else begin
               hold_next = hold_cnt + 16'd1;
            end
         end
         RUN: begin
            // Lock loss takes priority over a simultaneous ext_reset request
            if (!locked_s) begin
               state_next = WAIT_LOCK;
               lost_next  = sat_inc8(lock_lost_cnt);
            end else if (ext_reset) begin
               state_next = HOLD;
               hold_next  = '0;
            end
         end
         default: begin
            state_next = WAIT_LOCK;
            hold_next  = '0;
         end
      endcase
   end

   always_comb begin
      ce_pix   = (state == RUN) && (div_cnt == DIV_LAST);
      ce_cpu   = ce_pix && phase;
      run_stay = (state == RUN) && (state_next == RUN);
   end

   // Divider restarts from zero on every entry into RUN
   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt <= '0;
         phase   <= 1'b0;
      end else if (run_stay) begin
         div_cnt <= (div_cnt == DIV_LAST) ? 8'd0 : div_cnt + 8'd1;
         phase   <= phase ^ ce_pix;
      end else begin
         div_cnt <= '0;
         phase   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pll_rst_ce_gen.sv
// Self-checking bench for pll_rst_ce_gen with HOLD_CYCLES=16, CE_DIV=6.
module tb_pll_rst_ce_gen;

   localparam int HOLD_CYCLES = 16;
   localparam int CE_DIV      = 6;
   // Lock rise to RUN: 2 synchronizer edges + 1 lock-detect edge + 16 HOLD cycles
   localparam int LOCK_TO_RUN = 2 + 1 + HOLD_CYCLES;
   // Lock drop to WAIT_LOCK: 2 synchronizer edges + 1 transition edge
   localparam int LOSS_TO_RST = 3;
   localparam int M_WAIT = 0, M_HOLD = 1, M_RUN = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       pll_locked = 1'b0;
   logic       ext_reset = 1'b0;
   logic       sys_reset, ready, ce_pix, ce_cpu;
   logic [7:0] lock_lost_cnt;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_lost = 0;

   pll_rst_ce_gen #(.HOLD_CYCLES(HOLD_CYCLES), .CE_DIV(CE_DIV)) dut (
      .clk           (clk),
      .rst           (rst),
      .pll_locked    (pll_locked),
      .ext_reset     (ext_reset),
      .sys_reset     (sys_reset),
      .ready         (ready),
      .ce_pix        (ce_pix),
      .ce_cpu        (ce_cpu),
      .lock_lost_cnt (lock_lost_cnt)
   );

   always #5 clk = ~clk;

   // Reference model: mode, delayed lock history and count of cycles spent in RUN
   int m_mode = M_WAIT, m_hold = 0, m_run = 0, m_lost = 0;
   bit m_d1 = 1'b0, m_d2 = 1'b0, m_ls = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         m_mode = M_WAIT; m_hold = 0; m_run = 0; m_lost = 0; m_d1 = 1'b0; m_d2 = 1'b0;
      end else begin
         m_ls = m_d2;
         case (m_mode)
            M_WAIT: if (m_ls) begin m_mode = M_HOLD; m_hold = 0; end
            M_HOLD: begin
               if (!m_ls) m_mode = M_WAIT;
               else if (ext_reset) m_hold = 0;
               else if (m_hold == HOLD_CYCLES - 1) begin m_mode = M_RUN; m_run = 1; end
               else m_hold++;
            end
            default: begin
               if (!m_ls) begin m_mode = M_WAIT; if (m_lost < 255) m_lost++; end
               else if (ext_reset) begin m_mode = M_HOLD; m_hold = 0; end
               else m_run++;
            end
         endcase
         m_d2 = m_d1;
         m_d1 = pll_locked;
      end
   end

   task automatic wait_sys_reset(input logic level, input int max, output int cycles);
      cycles = 0;
      while (sys_reset !== level && cycles < max) begin
         @(negedge clk);
         cycles++;
      end
   endtask

   task automatic applyStimulus(input logic lock_v, input logic ext_v);
      pll_locked = lock_v;
      ext_reset  = ext_v;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      applyStimulus(1'($urandom_range(1)), 1'($urandom_range(1)));
      repeat (3) @(negedge clk);
      n_checks++; if (sys_reset !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_sys_reset: got %b expected 1", sys_reset); end
      n_checks++; if (ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ready: got %b expected 0", ready); end
      n_checks++; if (ce_pix !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ce_pix: got %b expected 0", ce_pix); end
      n_checks++; if (ce_cpu !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ce_cpu: got %b expected 0", ce_cpu); end
      n_checks++; if (lock_lost_cnt !== 8'd0) begin n_fail++; $display("[TB] FAIL reset_lost_cnt: got %0d expected 0", lock_lost_cnt); end
      rst = 1'b0;
      applyStimulus(1'b0, 1'b0);
      repeat (10) @(negedge clk);
      n_checks++; if (sys_reset !== 1'b1) begin n_fail++; $display("[TB] FAIL unlocked_hold: got %b expected 1", sys_reset); end
   endtask

   task automatic test_lock_sequence();
      int cycles, n_pix, n_cpu;
      int pix_pos[8];
      int cpu_pos[8];
      applyStimulus(1'b1, 1'b0);
      wait_sys_reset(1'b0, 200, cycles);
      n_checks++; if (cycles !== LOCK_TO_RUN) begin n_fail++; $display("[TB] FAIL lock_to_run: got %0d cycles expected %0d", cycles, LOCK_TO_RUN); end
      n_checks++; if (ready !== 1'b1) begin n_fail++; $display("[TB] FAIL ready_rise: got %b expected 1", ready); end
      n_pix = 0; n_cpu = 0;
      for (int rc = 1; rc <= 30; rc++) begin
         if (rc > 1) @(negedge clk);
         if (ce_pix === 1'b1) begin if (n_pix < 8) pix_pos[n_pix] = rc; n_pix++; end
         if (ce_cpu === 1'b1) begin if (n_cpu < 8) cpu_pos[n_cpu] = rc; n_cpu++; end
      end
      n_checks++; if (n_pix !== 5) begin n_fail++; $display("[TB] FAIL ce_pix_count: got %0d expected 5", n_pix); end
      n_checks++; if (n_cpu !== 2) begin n_fail++; $display("[TB] FAIL ce_cpu_count: got %0d expected 2", n_cpu); end
      for (int i = 0; i < 5 && i < n_pix; i++) begin
         n_checks++;
         if (pix_pos[i] !== CE_DIV * (i + 1)) begin n_fail++; $display("[TB] FAIL ce_pix_pos%0d: got cycle %0d expected %0d", i, pix_pos[i], CE_DIV * (i + 1)); end
      end
      if (n_cpu >= 2 && n_pix >= 4) begin
         n_checks++; if (cpu_pos[0] !== pix_pos[1]) begin n_fail++; $display("[TB] FAIL ce_cpu_first: got cycle %0d expected %0d", cpu_pos[0], pix_pos[1]); end
         n_checks++; if (cpu_pos[1] !== pix_pos[3]) begin n_fail++; $display("[TB] FAIL ce_cpu_second: got cycle %0d expected %0d", cpu_pos[1], pix_pos[3]); end
      end
   endtask

   task automatic test_lock_loss();
      int cycles;
      bit ce_seen;
      applyStimulus(1'b0, 1'b0);
      wait_sys_reset(1'b1, 20, cycles);
      exp_lost++;
      n_checks++; if (cycles !== LOSS_TO_RST) begin n_fail++; $display("[TB] FAIL loss_to_reset: got %0d cycles expected %0d", cycles, LOSS_TO_RST); end
      n_checks++; if (lock_lost_cnt !== 8'(exp_lost)) begin n_fail++; $display("[TB] FAIL loss_count: got %0d expected %0d", lock_lost_cnt, exp_lost); end
      ce_seen = 1'b0;
      repeat (8) begin
         if (ce_pix !== 1'b0 || ce_cpu !== 1'b0 || ready !== 1'b0) ce_seen = 1'b1;
         @(negedge clk);
      end
      n_checks++; if (ce_seen) begin n_fail++; $display("[TB] FAIL loss_outputs_quiet: got activity expected none"); end
      applyStimulus(1'b1, 1'b0);
      wait_sys_reset(1'b0, 200, cycles);
      n_checks++; if (cycles !== LOCK_TO_RUN) begin n_fail++; $display("[TB] FAIL relock_to_run: got %0d cycles expected %0d", cycles, LOCK_TO_RUN); end
   endtask

   task automatic test_ext_reset();
      int hi;
      applyStimulus(1'b1, 1'b1);
      @(negedge clk);
      applyStimulus(1'b1, 1'b0);
      hi = 0;
      while (sys_reset === 1'b1 && hi < 100) begin hi++; @(negedge clk); end
      n_checks++; if (hi !== HOLD_CYCLES) begin n_fail++; $display("[TB] FAIL ext_hold_len: got %0d expected %0d", hi, HOLD_CYCLES); end
      n_checks++; if (lock_lost_cnt !== 8'(exp_lost)) begin n_fail++; $display("[TB] FAIL ext_lost_cnt: got %0d expected %0d", lock_lost_cnt, exp_lost); end
      applyStimulus(1'b1, 1'b1);
      @(negedge clk);
      applyStimulus(1'b1, 1'b0);
      hi = 0;
      while (sys_reset === 1'b1 && hi < 100) begin
         hi++;
         ext_reset = (hi == 8);
         @(negedge clk);
      end
      ext_reset = 1'b0;
      n_checks++; if (hi !== 8 + HOLD_CYCLES) begin n_fail++; $display("[TB] FAIL ext_restart_len: got %0d expected %0d", hi, 8 + HOLD_CYCLES); end
   endtask

   task automatic test_back_to_back();
      int cycles;
      applyStimulus(1'b0, 1'b0);
      repeat (2) @(negedge clk);
      applyStimulus(1'b0, 1'b1);
      @(negedge clk);
      applyStimulus(1'b0, 1'b0);
      exp_lost++;
      n_checks++; if (sys_reset !== 1'b1) begin n_fail++; $display("[TB] FAIL collide_reset: got %b expected 1", sys_reset); end
      n_checks++; if (lock_lost_cnt !== 8'(exp_lost)) begin n_fail++; $display("[TB] FAIL collide_count: got %0d expected %0d", lock_lost_cnt, exp_lost); end
      repeat (3) @(negedge clk);
      applyStimulus(1'b1, 1'b0);
      wait_sys_reset(1'b0, 200, cycles);
      n_checks++; if (cycles !== LOCK_TO_RUN) begin n_fail++; $display("[TB] FAIL collide_relock: got %0d cycles expected %0d", cycles, LOCK_TO_RUN); end
   endtask

   task automatic test_rst_mid_run();
      n_checks++; if (lock_lost_cnt !== 8'd3) begin n_fail++; $display("[TB] FAIL pre_rst_count: got %0d expected 3", lock_lost_cnt); end
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      n_checks++; if (sys_reset !== 1'b1 || ready !== 1'b0) begin n_fail++; $display("[TB] FAIL midrun_rst_flags: got sys_reset=%b ready=%b expected 1/0", sys_reset, ready); end
      n_checks++; if (ce_pix !== 1'b0 || ce_cpu !== 1'b0) begin n_fail++; $display("[TB] FAIL midrun_rst_ce: got %b%b expected 00", ce_pix, ce_cpu); end
      n_checks++; if (lock_lost_cnt !== 8'd0) begin n_fail++; $display("[TB] FAIL midrun_rst_count: got %0d expected 0", lock_lost_cnt); end
      rst = 1'b0;
      exp_lost = 0;
   endtask

   task automatic test_random();
      bit e_sys, e_pix, e_cpu;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         e_sys = (m_mode != M_RUN);
         e_pix = (m_mode == M_RUN) && (m_run % CE_DIV == 0);
         e_cpu = e_pix && ((m_run / CE_DIV) % 2 == 0);
         n_checks++; if (sys_reset !== e_sys || ready !== !e_sys) begin n_fail++; $display("[TB] FAIL rnd_reset c%0d: got %b/%b expected %b/%b", c, sys_reset, ready, e_sys, !e_sys); end
         n_checks++; if (ce_pix !== e_pix || ce_cpu !== e_cpu) begin n_fail++; $display("[TB] FAIL rnd_ce c%0d: got %b%b expected %b%b", c, ce_pix, ce_cpu, e_pix, e_cpu); end
         n_checks++; if (lock_lost_cnt !== 8'(m_lost)) begin n_fail++; $display("[TB] FAIL rnd_lost c%0d: got %0d expected %0d", c, lock_lost_cnt, m_lost); end
         rst = ($urandom_range(599) == 0);
         if (pll_locked) pll_locked = ($urandom_range(79) != 0);
         else pll_locked = ($urandom_range(7) == 0);
         ext_reset = ($urandom_range(49) == 0);
      end
      rst = 1'b0;
      ext_reset = 1'b0;
   endtask

   task automatic test_saturation();
      int cycles, base, want;
      base = m_lost;
      for (int i = 0; i < 300; i++) begin
         applyStimulus(1'b1, 1'b0);
         wait_sys_reset(1'b0, 200, cycles);
         applyStimulus(1'b0, 1'b0);
         wait_sys_reset(1'b1, 20, cycles);
         @(negedge clk);
         want = (base + i + 1 > 255) ? 255 : base + i + 1;
         n_checks++;
         if (lock_lost_cnt !== 8'(want)) begin
            n_fail++;
            $display("[TB] FAIL sat_count i%0d: got %0d expected %0d", i, lock_lost_cnt, want);
         end
      end
      n_checks++; if (lock_lost_cnt !== 8'd255) begin n_fail++; $display("[TB] FAIL sat_final: got %0d expected 255", lock_lost_cnt); end
   endtask

   initial begin
      test_reset();
      test_lock_sequence();
      test_lock_loss();
      test_ext_reset();
      test_lock_loss();
      test_back_to_back();
      test_rst_mid_run();
      test_random();
      test_saturation();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
